// File: rtl/fortaegis_hist_seq.sv
// Run sequencer for the histogram chain array: clear bins, collect for win_len cycles, freeze, then stream all bins chain-major.
// Readout issues one bin read per 2 cycles at best; out_valid/data hold under out_ready low, with a one-entry skid for the in-flight read.
module fortaegis_hist_seq #(
  parameter int NCHAIN    = 4,
  parameter int ADDR_W    = 4,
  parameter int BIN_W     = 16,
  parameter int WIN_W     = 16,
  parameter int DRAIN_CYC = 8
) (
  input  logic                      clk200,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [WIN_W-1:0]          win_len,
  output logic                      coll,
  output logic                      stop4calc,
  output logic                      clr_we,
  output logic [ADDR_W-1:0]         clr_addr,
  output logic                      rd_en,
  output logic [$clog2(NCHAIN)-1:0] rd_chain,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [NCHAIN*BIN_W-1:0]   hist_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BIN_W-1:0]          out_data,
  output logic [$clog2(NCHAIN)-1:0] out_chain,
  output logic [ADDR_W-1:0]         out_addr,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);
  localparam int CW = $clog2(NCHAIN);
  localparam logic [CW-1:0]     LAST_CHAIN = CW'(NCHAIN - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_COLLECT, S_DRAIN, S_READ, S_DONE} state_t;

  state_t            state;
  logic [WIN_W-1:0]  win_r;
  logic [WIN_W-1:0]  cnt;
  logic [CW-1:0]     nxt_chain;
  logic [ADDR_W-1:0] nxt_addr;
  logic              issued_all;
  logic              rd_q;
  logic              skid_vld;
  logic [BIN_W-1:0]  skid_dat;
  logic [CW-1:0]     skid_chain;
  logic [ADDR_W-1:0] skid_addr;
  logic              skid_last;

  // rd_chain/rd_addr still name the returning read while its data is on hist_rdata
  logic [BIN_W-1:0] land_dat;
  logic             land_last;
  logic             accept;
  assign land_dat  = hist_rdata[rd_chain*BIN_W +: BIN_W];
  assign land_last = (rd_chain == LAST_CHAIN) && (rd_addr == LAST_ADDR);
  assign accept    = out_valid && out_ready;

  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;     win_r <= '0;       cnt <= '0;
      coll <= 1'b0;        stop4calc <= 1'b0; clr_we <= 1'b0;   clr_addr <= '0;
      rd_en <= 1'b0;       rd_chain <= '0;    rd_addr <= '0;
      out_valid <= 1'b0;   out_data <= '0;    out_chain <= '0;  out_addr <= '0;
      out_last <= 1'b0;    busy <= 1'b0;      done <= 1'b0;
      nxt_chain <= '0;     nxt_addr <= '0;    issued_all <= 1'b0; rd_q <= 1'b0;
      skid_vld <= 1'b0;    skid_dat <= '0;    skid_chain <= '0; skid_addr <= '0;
      skid_last <= 1'b0;
    end else if (abort) begin
      // abandon the run; any in-flight read result is simply never captured
      state <= S_IDLE;     cnt <= '0;
      coll <= 1'b0;        stop4calc <= 1'b0; clr_we <= 1'b0;   clr_addr <= '0;
      rd_en <= 1'b0;       rd_chain <= '0;    rd_addr <= '0;
      out_valid <= 1'b0;   out_data <= '0;    out_chain <= '0;  out_addr <= '0;
      out_last <= 1'b0;    busy <= 1'b0;      done <= 1'b0;
      nxt_chain <= '0;     nxt_addr <= '0;    issued_all <= 1'b0; rd_q <= 1'b0;
      skid_vld <= 1'b0;    skid_dat <= '0;    skid_chain <= '0; skid_addr <= '0;
      skid_last <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state    <= S_CLEAR;
          busy     <= 1'b1;
          clr_we   <= 1'b1;
          clr_addr <= '0;
          win_r    <= (win_len == '0) ? WIN_W'(1) : win_len;
        end
        S_CLEAR: if (clr_addr == LAST_ADDR) begin
          clr_we   <= 1'b0;
          clr_addr <= '0;
          coll     <= 1'b1;
          cnt      <= '0;
          state    <= S_COLLECT;
        end else begin
          clr_addr <= clr_addr + 1'b1;
        end
        S_COLLECT: if (cnt == win_r - 1'b1) begin
          coll      <= 1'b0;
          stop4calc <= 1'b1;
          cnt       <= '0;
          state     <= S_DRAIN;
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_DRAIN: if (cnt == WIN_W'(DRAIN_CYC - 1)) begin
          cnt        <= '0;
          nxt_chain  <= '0;
          nxt_addr   <= '0;
          issued_all <= 1'b0;
          state      <= S_READ;
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_READ: begin
          rd_q <= rd_en;
          if (!rd_en && !issued_all && (!out_valid || out_ready)) begin
            rd_en    <= 1'b1;
            rd_chain <= nxt_chain;
            rd_addr  <= nxt_addr;
            if (nxt_addr == LAST_ADDR) begin
              nxt_addr <= '0;
              if (nxt_chain == LAST_CHAIN) issued_all <= 1'b1;
              else                         nxt_chain  <= nxt_chain + 1'b1;
            end else begin
              nxt_addr <= nxt_addr + 1'b1;
            end
          end else begin
            rd_en <= 1'b0;
          end
          // a read issued alongside a presented beat may land before that beat is taken
          if (accept) begin
            if (skid_vld) begin
              out_data  <= skid_dat;
              out_chain <= skid_chain;
              out_addr  <= skid_addr;
              out_last  <= skid_last;
              skid_vld  <= 1'b0;
            end else if (rd_q) begin
              out_data  <= land_dat;
              out_chain <= rd_chain;
              out_addr  <= rd_addr;
              out_last  <= land_last;
            end else begin
              out_valid <= 1'b0;
            end
          end else if (rd_q) begin
            if (!out_valid) begin
              out_valid <= 1'b1;
              out_data  <= land_dat;
              out_chain <= rd_chain;
              out_addr  <= rd_addr;
              out_last  <= land_last;
            end else begin
              skid_vld   <= 1'b1;
              skid_dat   <= land_dat;
              skid_chain <= rd_chain;
              skid_addr  <= rd_addr;
              skid_last  <= land_last;
            end
          end
          if (accept && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          done      <= 1'b0;
          stop4calc <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fortaegis_hist_seq.sv
// Directed bench for fortaegis_hist_seq; bin memory model returns chain c bin a as c*256+a, one cycle after rd_en.
module tb_fortaegis_hist_seq;
  logic        clk200 = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] win_len = '0;
  logic        out_ready = 1'b1;
  logic [63:0] hist_rdata = '0;
  logic        coll, stop4calc, clr_we, rd_en, out_valid, out_last, busy, done;
  logic [3:0]  clr_addr, rd_addr, out_addr;
  logic [1:0]  rd_chain, out_chain;
  logic [15:0] out_data;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  fortaegis_hist_seq dut (
    .clk200(clk200), .rst(rst), .start(start), .abort(abort), .win_len(win_len),
    .coll(coll), .stop4calc(stop4calc), .clr_we(clr_we), .clr_addr(clr_addr),
    .rd_en(rd_en), .rd_chain(rd_chain), .rd_addr(rd_addr), .hist_rdata(hist_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chain(out_chain), .out_addr(out_addr), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk200 = ~clk200;
  always @(posedge clk200) cyc <= cyc + 1;

  // data is only meaningful in the cycle right after rd_en
  always @(posedge clk200) begin
    if (rd_en) begin
      for (int c = 0; c < 4; c++) hist_rdata[c*16 +: 16] <= 16'(c*256 + int'(rd_addr));
    end else begin
      hist_rdata <= {4{16'hDEAD}};
    end
  end

  task automatic step();
    @(negedge clk200);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_run(input logic [15:0] wl, input int exp_coll, input int stall_beat, input int abort_beat);
    int prev;
    int n;
    win_len = wl; start = 1'b1;
    step();
    start = 1'b0; win_len = 16'h00AA;
    for (int i = 0; i < 16; i++) begin
      chk("clr_we", clr_we, 1);
      chk("clr_addr", clr_addr, i);
      chk("coll_in_clear", coll, 0);
      chk("busy_in_clear", busy, 1);
      // a start while busy must not relatch the window
      if (i == 3) begin start = 1'b1; win_len = 16'd7; end
      if (i == 4) start = 1'b0;
      step();
    end
    for (int i = 0; i < exp_coll; i++) begin
      chk("coll_high", coll, 1);
      chk("clr_we_in_coll", clr_we, 0);
      step();
    end
    chk("coll_end", coll, 0);
    chk("stop4calc_drain", stop4calc, 1);
    prev = -1;
    for (int k = 0; k < 64; k++) begin
      n = 0;
      while (!out_valid && n < 40) begin step(); n++; end
      if (!out_valid) begin
        chk("valid_timeout", out_valid, 1);
        return;
      end
      chk("out_chain", out_chain, k / 16);
      chk("out_addr", out_addr, k % 16);
      chk("out_data", out_data, (k / 16) * 256 + (k % 16));
      chk("out_last", out_last, (k == 63) ? 1 : 0);
      chk("stop4calc_read", stop4calc, 1);
      if (prev >= 0 && k != stall_beat + 1) chk("beat_spacing", cyc - prev, 2);
      prev = cyc;
      if (k == abort_beat) begin
        abort = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_stop4calc", stop4calc, 0);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_done", done, 0);
        for (int i = 0; i < 5; i++) begin
          step();
          chk("post_abort_busy", busy, 0);
          chk("post_abort_done", done, 0);
          chk("post_abort_clr", clr_we, 0);
        end
        return;
      end
      if (k == stall_beat) begin
        out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
          step();
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, (k / 16) * 256 + (k % 16));
          chk("stall_chain", out_chain, k / 16);
          chk("stall_addr", out_addr, k % 16);
          chk("stall_rd_en", rd_en, 0);
        end
        out_ready = 1'b1;
      end
      step();
    end
    chk("done_pulse", done, 1);
    chk("done_valid", out_valid, 0);
    step();
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_stop4calc", stop4calc, 0);
  endtask

  initial begin
    step(); step(); step();
    chk("rst_coll", coll, 0);
    chk("rst_stop4calc", stop4calc, 0);
    chk("rst_clr_we", clr_we, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_last", out_last, 0);
    rst = 1'b0;
    step();

    do_run(16'd5, 5, -1, -1);   // nominal run, continuous ready
    do_run(16'd0, 1, 19, -1);   // zero window, stall on chain1 addr3
    do_run(16'd2, 2, -1, 5);    // abort with start during readout
    do_run(16'd3, 3, -1, -1);   // clean run after abort

    // asynchronous reset in the middle of collection
    win_len = 16'd20; start = 1'b1;
    step();
    start = 1'b0;
    repeat (18) step();
    chk("midcoll_coll", coll, 1);
    rst = 1'b1;
    #1;
    chk("arst_coll", coll, 0);
    chk("arst_stop4calc", stop4calc, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", out_valid, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_coll", coll, 0);
    chk("post_rst_clr_we", clr_we, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
